// File: rtl/ring_output_arbiter.sv
// Output-port controller for one ring direction: two requesters fill per-VC one-flit
// buffers, and the buffered flit of the active VC goes out on the link.
// Optional grant/contention counters are enabled with `define ARB_GRANT_CNT_EN.
module ring_output_arbiter #(
    parameter int DATA_WIDTH       = 64,
    parameter int INITIAL_PRIORITY = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  polarity,
    input  logic                  rq0_vld,
    input  logic                  rq0_vc,
    input  logic [DATA_WIDTH-1:0] rq0_data,
    input  logic                  rq1_vld,
    input  logic                  rq1_vc,
    input  logic [DATA_WIDTH-1:0] rq1_data,
    output logic                  gt0,
    output logic                  gt1,
    output logic                  so,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic [1:0]            ri
`ifdef ARB_GRANT_CNT_EN
    ,
    output logic [15:0]           gnt_cnt0,
    output logic [15:0]           gnt_cnt1,
    output logic [15:0]           contention_cnt
`endif
);

    localparam logic INIT_PRIO = 1'(INITIAL_PRIORITY);

    logic [1:0]            ob_full;
    logic [DATA_WIDTH-1:0] ob_data [2];
    logic [1:0]            prio_v;

    logic tgt;
    logic snd;
    logic elig0;
    logic elig1;
    logic can_fill;
    logic contention;
    logic granted;

    // Fill the idle VC while the active VC drives the link.
    always_comb begin
        // NOTE: every output of this block is assigned a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        gt0        = 1'b0;
        gt1        = 1'b0;
        tgt        = ~polarity;
        snd        = polarity;
        elig0      = rq0_vld && (rq0_vc == tgt);
        elig1      = rq1_vld && (rq1_vc == tgt);
        can_fill   = !reset && !ob_full[tgt];
        contention = elig0 && elig1;
        if (can_fill) begin
            if (contention) begin
                gt0 = (prio_v[tgt] == 1'b0);
                gt1 = (prio_v[tgt] == 1'b1);
            end else begin
                gt0 = elig0;
                gt1 = elig1;
            end
        end
        granted = gt0 || gt1;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            ob_full    <= '0;
            // NOTE: the two flit buffers are cleared explicitly; they are a register
            // pair, not a RAM, so resetting them is cheap and keeps dout deterministic.
            ob_data[0] <= '0;
            ob_data[1] <= '0;
            so         <= 1'b0;
            dout       <= '0;
            prio_v     <= {2{INIT_PRIO}};
        end else begin
            so <= 1'b0;
            if (ob_full[snd] && ri[snd]) begin
                so           <= 1'b1;
                dout         <= ob_data[snd];
                ob_full[snd] <= 1'b0;
            end
            // snd and tgt always differ, so send and fill never touch the same buffer.
            if (granted) begin
                ob_full[tgt] <= 1'b1;
                ob_data[tgt] <= gt0 ? rq0_data : rq1_data;
            end
            // The loser of a contended grant takes priority; an uncontended cycle re-arms it.
            if (!contention) begin
                prio_v[tgt] <= INIT_PRIO;
            end else if (granted) begin
                prio_v[tgt] <= gt0;
            end
        end
    end

`ifdef ARB_GRANT_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_cnt0       <= '0;
            gnt_cnt1       <= '0;
            contention_cnt <= '0;
        end else begin
            if (gt0 && gnt_cnt0 != 16'hFFFF) begin
                gnt_cnt0 <= gnt_cnt0 + 16'd1;
            end
            if (gt1 && gnt_cnt1 != 16'hFFFF) begin
                gnt_cnt1 <= gnt_cnt1 + 16'd1;
            end
            if (granted && contention && contention_cnt != 16'hFFFF) begin
                contention_cnt <= contention_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
